// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl <-> cpu_dp / instruction memory bundle.
// Control word, register addresses, PC and status feedback.
interface cpu_ctrl_if;
  logic [15:0] inst;
  logic [3:0]  psw;
  logic [12:0] cw;
  logic [2:0]  DA;
  logic [2:0]  AA;
  logic [2:0]  BA;
  logic [8:0]  pc;
  logic        halted;

  modport master (
    input  inst,
    input  psw,
    output cw,
    output DA,
    output AA,
    output BA,
    output pc,
    output halted
  );

  modport slave (
    output inst,
    output psw,
    input  cw,
    input  DA,
    input  AA,
    input  BA,
    input  pc,
    input  halted
  );
endinterface

// File: rtl/cpu_ctrl.sv
// Instruction-sequencing control unit for cpu_dp.
// Fetch/execute FSM; outputs decoded from state, IR and psw.
module cpu_ctrl #(
  parameter logic [4:0] FS_ADD = 5'b00010
) (
  input  logic       clk,
  input  logic       rstn,
  cpu_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    INF = 2'd0,
    EX0 = 2'd1,
    EX1 = 2'd2,
    HLT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [8:0]  pc_q, pc_d;
  logic        halted_q, halted_d;

  logic [1:0]  cls;
  logic [4:0]  sub;
  logic [2:0]  ir_da, ir_aa, ir_ba;
  logic [5:0]  off;
  logic [8:0]  pc_br;

  logic        is_alu, is_imm;
  logic        is_ld, is_st, is_ldx;
  logic        is_brz, is_brn, is_jmp, is_hlt;

  logic        td, ta, mb, md, rw, mm, mw;
  logic [4:0]  fs;
  logic [2:0]  da, aa, ba;

  assign cls   = ir_q[15:14];
  assign sub   = ir_q[13:9];
  assign ir_da = ir_q[8:6];
  assign ir_aa = ir_q[5:3];
  assign ir_ba = ir_q[2:0];
  assign off   = {ir_da, ir_ba};
  assign pc_br = pc_q + {{3{off[5]}}, off};

  assign is_alu = (cls == 2'b00);
  assign is_imm = (cls == 2'b01);
  assign is_ld  = (cls == 2'b10) && (sub == 5'd0);
  assign is_st  = (cls == 2'b10) && (sub == 5'd1);
  assign is_ldx = (cls == 2'b10) && (sub == 5'd2);
  assign is_brz = (cls == 2'b11) && (sub == 5'd0);
  assign is_brn = (cls == 2'b11) && (sub == 5'd1);
  assign is_jmp = (cls == 2'b11) && (sub == 5'd2);
  assign is_hlt = (cls == 2'b11) && (sub == 5'd3);

  // State, IR, PC and halt flag registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= INF;
      ir_q     <= '0;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Next-state and control-word decode
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    td = 1'b0;
    ta = 1'b0;
    mb = 1'b0;
    md = 1'b0;
    rw = 1'b0;
    mm = 1'b0;
    mw = 1'b0;
    fs = 5'd0;
    da = 3'd0;
    aa = 3'd0;
    ba = 3'd0;
    case (state_q)
      INF: begin
        mm      = 1'b1;
        ir_d    = bus.inst;
        pc_d    = pc_q + 9'd1;
        state_d = EX0;
      end
      EX0: begin
        da      = ir_da;
        aa      = ir_aa;
        ba      = ir_ba;
        state_d = INF;
        unique case (1'b1)
          is_alu: begin
            fs = sub;
            rw = 1'b1;
          end
          is_imm: begin
            fs = sub;
            mb = 1'b1;
            rw = 1'b1;
          end
          is_ld: begin
            md = 1'b1;
            rw = 1'b1;
          end
          is_st: begin
            mw = 1'b1;
          end
          is_ldx: begin
            td      = 1'b1;
            da      = 3'd0;
            fs      = FS_ADD;
            rw      = 1'b1;
            state_d = EX1;
          end
          is_brz: begin
            if (bus.psw[0]) pc_d = pc_br;
          end
          is_brn: begin
            if (bus.psw[1]) pc_d = pc_br;
          end
          is_jmp: begin
            pc_d = pc_br;
          end
          is_hlt: begin
            halted_d = 1'b1;
            state_d  = HLT;
          end
          default: ;
        endcase
      end
      EX1: begin
        ta      = 1'b1;
        md      = 1'b1;
        rw      = 1'b1;
        da      = ir_da;
        ba      = ir_ba;
        state_d = INF;
      end
      HLT: begin
        halted_d = 1'b1;
      end
      default: state_d = INF;
    endcase
  end

  assign bus.cw     = {td, ta, 1'b0, mb, fs, md, rw, mm, mw};
  assign bus.DA     = da;
  assign bus.AA     = aa;
  assign bus.BA     = ba;
  assign bus.pc     = pc_q;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed testbench for cpu_ctrl.
// Program image in a local memory; checks sampled 1ns after posedge.
module tb_cpu_ctrl;

  logic clk;
  logic rstn;
  logic [15:0] mem [512];

  int n_chk;
  int n_err;

  cpu_ctrl_if bus ();

  cpu_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  assign bus.inst = mem[bus.pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(
    input logic [6:0] op,
    input logic [2:0] da,
    input logic [2:0] aa,
    input logic [2:0] ba
  );
    return {op, da, aa, ba};
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[0]   = 16'h04D3;
    mem[1]   = mk(7'h22, 3'd1, 3'd0, 3'd5);
    mem[2]   = mk(7'h41, 3'd0, 3'd2, 3'd3);
    mem[3]   = mk(7'h40, 3'd4, 3'd1, 3'd0);
    mem[4]   = mk(7'h42, 3'd4, 3'd1, 3'd2);
    mem[5]   = mk(7'h60, 3'b111, 3'd0, 3'b110);
    mem[6]   = mk(7'h61, 3'b000, 3'd0, 3'b001);
    mem[8]   = mk(7'h43, 3'd0, 3'd0, 3'd0);
    mem[9]   = mk(7'h62, 3'b110, 3'd0, 3'b101);
    mem[511] = mk(7'h62, 3'b000, 3'd0, 3'b001);
    bus.psw = 4'b0000;
    rstn = 1'b0;

    #2;
    check("rst_cw", 32'(bus.cw), 32'h002);
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_DA", 32'(bus.DA), 32'd0);
    #1 rstn = 1'b1;

    step();
    check("alu_pc", 32'(bus.pc), 32'd1);
    check("alu_cw", 32'(bus.cw), 32'h0024);
    check("alu_DA", 32'(bus.DA), 32'd3);
    check("alu_AA", 32'(bus.AA), 32'd2);
    check("alu_BA", 32'(bus.BA), 32'd3);
    step();
    check("inf_cw", 32'(bus.cw), 32'h002);
    check("inf_AA", 32'(bus.AA), 32'd0);

    step();
    check("imm_cw", 32'(bus.cw), 32'h0224);
    check("imm_BA", 32'(bus.BA), 32'd5);
    check("imm_DA", 32'(bus.DA), 32'd1);
    step();

    step();
    check("st_cw", 32'(bus.cw), 32'h0001);
    check("st_pc", 32'(bus.pc), 32'd3);
    step();

    step();
    check("ld_cw", 32'(bus.cw), 32'h000C);
    step();

    step();
    check("ldx0_cw", 32'(bus.cw), 32'h1024);
    check("ldx0_DA", 32'(bus.DA), 32'd0);
    check("ldx0_AA", 32'(bus.AA), 32'd1);
    check("ldx0_BA", 32'(bus.BA), 32'd2);
    step();
    check("ldx1_cw", 32'(bus.cw), 32'h080C);
    check("ldx1_AA", 32'(bus.AA), 32'd0);
    check("ldx1_DA", 32'(bus.DA), 32'd4);
    step();
    check("ldx_inf_cw", 32'(bus.cw), 32'h002);
    check("ldx_inf_pc", 32'(bus.pc), 32'd5);

    bus.psw = 4'b0001;
    step();
    check("brz_ex_pc", 32'(bus.pc), 32'd6);
    check("brz_ex_cw", 32'(bus.cw), 32'h0);
    step();
    check("brz_taken_pc", 32'(bus.pc), 32'd4);

    step();
    step();
    step();
    check("ldx2_pc", 32'(bus.pc), 32'd5);
    bus.psw = 4'b0000;
    step();
    step();
    check("brz_nt_pc", 32'(bus.pc), 32'd6);

    bus.psw = 4'b0010;
    step();
    step();
    check("brn_taken_pc", 32'(bus.pc), 32'd8);
    bus.psw = 4'b0000;

    step();
    check("nop_cw", 32'(bus.cw), 32'h0);
    check("nop_pc", 32'(bus.pc), 32'd9);
    step();

    step();
    step();
    check("jmp_back_pc", 32'(bus.pc), 32'd511);

    mem[1] = mk(7'h63, 3'd0, 3'd0, 3'd0);
    step();
    check("jmp_wrap_ex_pc", 32'(bus.pc), 32'd0);
    step();
    check("jmp_wrap_pc", 32'(bus.pc), 32'd1);

    step();
    check("hlt_ex_halted", 32'(bus.halted), 32'd0);
    check("hlt_ex_pc", 32'(bus.pc), 32'd2);
    for (int i = 0; i < 20; i++) begin
      step();
      check("hlt_pc", 32'(bus.pc), 32'd2);
      check("hlt_halted", 32'(bus.halted), 32'd1);
      check("hlt_cw", 32'(bus.cw), 32'h0);
    end

    rstn = 1'b0;
    #1;
    check("hrst_pc", 32'(bus.pc), 32'd0);
    check("hrst_halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    mem[0] = mk(7'h42, 3'd4, 3'd1, 3'd2);
    rstn = 1'b1;

    step();
    check("ldx3_cw", 32'(bus.cw), 32'h1024);
    step();
    check("ldx3_ex1_cw", 32'(bus.cw), 32'h080C);
    rstn = 1'b0;
    #1;
    check("mrst_cw", 32'(bus.cw), 32'h002);
    check("mrst_pc", 32'(bus.pc), 32'd0);
    check("mrst_halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    check("mrst_fetch_pc", 32'(bus.pc), 32'd1);
    check("mrst_fetch_cw", 32'(bus.cw), 32'h1024);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
